// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM: pointers, occupancy, registered status and sticky errors.
// Read data appears on dout one cycle after an accepted pop; a full FIFO accepts a push only alongside a pop.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_P = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  active;
    logic [ADDR_WIDTH:0]   level_nxt;

    // Reset and clear both suppress every RAM access in their cycle.
    assign active  = rst_n && !clear;
    assign pop_ok  = active && pop && !empty;
    assign push_ok = active && push && (!full || pop_ok);

    assign ram_wr      = push_ok;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = push_data;
    assign ram_rd      = pop_ok;
    assign ram_rd_addr = rd_ptr;

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop_ok)
            level_nxt = level + ONE_L;
        else if (pop_ok && !push_ok)
            level_nxt = level - ONE_L;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            dout_valid  <= 1'b0;
            dout        <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            dout_valid  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + ONE_P;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE_P;
                dout   <= ram_rd_data;
            end
            dout_valid  <= pop_ok;
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == DEPTH);
            almost_full <= (level_nxt >= AFULL_L);
            if (push && !push_ok)
                overflow <= 1'b1;
            if (pop && empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the FIFO word width, equal to the width of the attached dp_ram.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the dp_ram address width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_LEVEL, default 2^ADDR_WIDTH-4, meaning the almost_full threshold.
REQ-004 SHALL have a single clock and a reset that is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 clear  in  1  synchronous flush; same effect as reset on all state except dout.
REQ-008 push  in  1  write request.
REQ-009 push_data  in  DATA_WIDTH  write word.
REQ-010 pop  in  1  read request.
REQ-011 dout  out  DATA_WIDTH  registered read word.
REQ-012 dout_valid  out  1  one-cycle pulse; dout is valid while it is high.
REQ-013 full, empty, almost_full  out  1 each  status flags, all registered.
REQ-014 level  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
REQ-015 overflow, underflow  out  1 each  sticky error flags.
REQ-016 ram_wr  out  1  RAM write strobe.
REQ-017 ram_wr_addr  out  ADDR_WIDTH  RAM write address.
REQ-018 ram_wr_data  out  DATA_WIDTH  RAM write data.
REQ-019 ram_rd  out  1  RAM read strobe.
REQ-020 ram_rd_addr  out  ADDR_WIDTH  RAM read address.
REQ-021 ram_rd_data  in  DATA_WIDTH  combinational RAM read data; valid in the same cycle as ram_rd_addr.

Function
REQ-022 Accepted push (push_ok) SHALL be push && (!full || pop_ok).
REQ-023 Accepted pop (pop_ok) SHALL be pop && !empty; empty-FIFO pop is never bypassed from push_data.
REQ-024 ram_wr SHALL equal push_ok combinationally, with ram_wr_addr = wr_ptr and ram_wr_data = push_data.
REQ-025 ram_rd SHALL equal pop_ok, and ram_rd_addr SHALL always be rd_ptr.
REQ-026 On pop_ok, dout SHALL load ram_rd_data and dout_valid SHALL be 1 in the next cycle, giving 1-cycle latency.
REQ-027 dout SHALL hold its value otherwise, and dout_valid SHALL be 0 whenever pop_ok was 0 in the previous cycle.
REQ-028 wr_ptr and rd_ptr SHALL be ADDR_WIDTH bits, increment by 1 on push_ok and pop_ok respectively, and wrap from 2^ADDR_WIDTH-1 to 0.
REQ-029 level SHALL be +1 on push_ok only, -1 on pop_ok only, and unchanged on both or neither.
REQ-030 empty SHALL be (level==0), full SHALL be (level==2^ADDR_WIDTH), and almost_full SHALL be (level>=AFULL_LEVEL), all evaluated on the next-state level.
REQ-031 When full, push && pop SHALL accept both, overwriting the slot freed in the same cycle, with level unchanged.
REQ-032 push && !push_ok SHALL set overflow; pop && empty SHALL set underflow; both flags stay set until reset or clear.
REQ-033 Rejected requests SHALL NOT change pointers, level or the RAM.
REQ-034 clear SHALL take priority over push/pop in its cycle: no RAM write, no dout_valid next cycle.

Reset
REQ-035 While rst_n is 0 at a clock edge, wr_ptr, rd_ptr, level, overflow, underflow, dout_valid and dout SHALL go to 0, empty to 1, full and almost_full to 0.
REQ-036 Reset SHALL dominate clear and push/pop; ram_wr and ram_rd SHALL be 0 during any cycle with rst_n=0, so a reset mid-stream discards all contents.
REQ-037 RAM contents SHALL NOT be initialised; correctness SHALL rely only on the pointers.

Verification
REQ-038 Push 0x11,0x22,0x33, then pop 3 times -> dout 0x11,0x22,0x33 each one cycle after its pop, level 3->0, empty=1.
REQ-039 ADDR_WIDTH=3: push 8 words -> full=1, level=8; 9th push -> overflow=1, level stays 8; push+pop while full -> both accepted, level 8.
REQ-040 Pop while empty with push=1 in the same cycle -> underflow=1, no dout_valid, level=1 after the edge.
REQ-041 ADDR_WIDTH=3: 20 interleaved push/pop cycles crossing the pointer wrap -> data order preserved, ram_wr_addr sequence 6,7,0,1.
REQ-042 Assert rst_n=0 with level=5 and push=pop=1 -> ram_wr=ram_rd=0, level=0, empty=1 and flags=0 after the edge.
REQ-043 Assert clear with level=4 -> level=0 and sticky flags cleared; the next push/pop sequence returns correct data.
